nabp_filtered_ram_swap_control: RTL and testbench
=================================================

// Module: nabp_filtered_ram_swap_control
// PURPOSE
//  Ping-pong store for filtered projections, between the filter stage and the processing swap control.
//  The filter writes one angle's projection into the write bank. The processing side reads the read
//  bank on two independent s ports (one per swappable). Banks swap on a zero-latency next-angle handshake.
// PARAMETERS
//  ANGLE_W   9    angle code width (= `kAngleLength)
//  DATA_W    12   signed filtered sample width (= `kFilteredDataLength)
//  S_W       10   signed s index width (= `kSLength)
//  PROJ_LEN  512  samples per projection; power of two, <= 2**S_W
// PORTS
//  clk               in   1        sole clock, rising edge
//  reset             in   1        synchronous, active-high
//  flt_angle         in   ANGLE_W  angle of incoming projection; sampled with first accepted sample
//  flt_valid         in   1        filter sample valid
//  flt_data          in   DATA_W   signed filtered sample, s ascending from -PROJ_LEN/2
//  flt_last          in   1        marks final sample of projection
//  flt_ready         out  1        write bank accepting samples
//  fr_angle          out  ANGLE_W  angle held in read bank
//  fr_has_next_angle out  1        a complete projection waits in write bank
//  fr_next_angle     in   1        processing requests swap
//  fr_next_angle_ack out  1        swap granted this cycle
//  fr0_s_val         in   S_W      signed s, read port 0
//  fr1_s_val         in   S_W      signed s, read port 1
//  fr0_val           out  DATA_W   signed sample for fr0_s_val of previous cycle
//  fr1_val           out  DATA_W   signed sample for fr1_s_val of previous cycle
//  err_len           out  1        sticky: flt_last disagreed with PROJ_LEN count
// BEHAVIOUR
//  Reset values: flt_ready=1, fr_angle=0, fr_has_next_angle=0, fr_next_angle_ack=0, fr*_val=0,
//   err_len=0, wr_sel=0, rd_sel=1, wr_cnt=0. Write state is WR_FILL. RAM contents are not cleared.
//  Write FSM, two states:
//   WR_FILL: flt_ready=1. Each flt_valid writes bank[wr_sel][wr_cnt], then wr_cnt++.
//    The first sample (wr_cnt=0) latches flt_angle into pend_angle.
//    The sample with wr_cnt==PROJ_LEN-1 moves the FSM to WR_WAIT and clears wr_cnt.
//    If flt_last does not coincide with wr_cnt==PROJ_LEN-1, err_len<=1.
//    An early flt_last does not truncate the projection.
//   WR_WAIT: flt_ready=0 and fr_has_next_angle=1, both registered from state.
//  Swap handshake:
//   fr_next_angle_ack = fr_next_angle & fr_has_next_angle. Combinational, same cycle as the request;
//    the processing swap control depends on this zero latency.
//   On the ack edge: rd_sel<=wr_sel, wr_sel<=~wr_sel, fr_angle<=pend_angle, FSM->WR_FILL.
//    fr_angle is therefore valid from the cycle after the ack.
//   A request while fr_has_next_angle=0 is ignored, not latched; the requester re-asserts.
//   Before the first swap the read bank content is undefined and fr_angle=0.
//  Read path, both ports identical, 1-cycle latency:
//   addr = s + PROJ_LEN/2, computed at S_W+1 bits signed.
//   In range when 0 <= addr < PROJ_LEN. Out of range forces fr*_val=0 the next cycle.
//   The bank select used is rd_sel as registered at the edge where the address is sampled.
//    A read issued in the ack cycle returns the OLD bank.
//   Both ports may address the same location in the same cycle; both return the same data.
//  Simultaneous events: a write to the write bank and reads from the read bank never conflict,
//   because the banks are disjoint. No write can occur in the ack cycle (flt_ready=0).
//  Reset mid-operation: the partial fill is discarded and the pending angle is lost.
//   Outputs return to their reset values on the next edge.
// STRUCTURE
//  The shared defines header carries: kAngleLength, kFilteredDataLength, kSLength, PROJ_LEN
//   and its log2, and the WR_FILL/WR_WAIT encodings (generated enum, as for the other swap controls).
//  Sub-module nabp_filtered_ram_bank: PROJ_LEN x DATA_W, 1 write port and 2 registered read ports.
//   Instantiated twice. Write and read selects are muxed in the top level.
//  Top level contains: write FSM, wr_cnt, pend_angle, swap logic, s->addr range check, output muxes.
// TESTING
//  1. Fill 512 samples of ramp data=s, angle=30, then pulse fr_next_angle.
//     -> ack on the same cycle; fr_angle=30 on the next cycle; s=-256..255 reads back -256..255.
//  2. Request fr_next_angle mid-fill (wr_cnt=100).
//     -> ack=0, no swap; flt_ready stays 1; fill completes normally.
//  3. Read both ports with s=-257 and s=256.
//     -> fr0_val=fr1_val=0; s=-256 and s=255 return the first and last samples.
//  4. Hold a full bank (angle=60), keep reading angle 30 with s=5, then swap and read s=5 in the ack cycle.
//     -> the read returns the angle-30 value; the following read returns the angle-60 value.
//  5. Assert flt_last at sample 300.
//     -> err_len=1 sticky; the bank still fills to 512; reset clears err_len.
//  6. Assert reset at wr_cnt=200 with a bank pending.
//     -> next cycle has_next=0, flt_ready=1, fr_angle=0; a new fill starts at wr_cnt=0 in bank 0.

Source files
------------

// File: rtl/nabp_filtered_ram_swap_control_pkg.sv
// Shared definitions for the filtered-projection ping-pong store.
package nabp_filtered_ram_swap_control_pkg;

  localparam int kAngleLength        = 9;
  localparam int kFilteredDataLength = 12;
  localparam int kSLength            = 10;
  localparam int PROJ_LEN            = 512;
  localparam int PROJ_LEN_LOG2       = 9;

  // Write-side states: filling the write bank, or holding a complete projection.
  typedef enum logic [0:0] {
    WR_FILL = 1'b0,
    WR_WAIT = 1'b1
  } wr_state_e;

endpackage

// File: rtl/nabp_filtered_ram_swap_control_bank.sv
// One projection bank: single write port, two independent registered read ports.
module nabp_filtered_ram_swap_control_bank #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Sample store; contents are deliberately never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered reads, one cycle latency on each port.
  always_ff @(posedge clk) begin
    rdata0 <= mem_r[raddr0];
    rdata1 <= mem_r[raddr1];
  end

endmodule

// File: rtl/nabp_filtered_ram_swap_control.sv
// Ping-pong store between the filter stage and the processing swap control.
// The filter fills the write bank; processing reads the read bank on two ports;
// a zero-latency next-angle handshake swaps the banks.
module nabp_filtered_ram_swap_control
  import nabp_filtered_ram_swap_control_pkg::*;
#(
  parameter int ANGLE_W  = kAngleLength,
  parameter int DATA_W   = kFilteredDataLength,
  parameter int S_W      = kSLength,
  parameter int PROJ_LEN = nabp_filtered_ram_swap_control_pkg::PROJ_LEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ANGLE_W-1:0] flt_angle,
  input  logic               flt_valid,
  input  logic [DATA_W-1:0]  flt_data,
  input  logic               flt_last,
  output logic               flt_ready,
  output logic [ANGLE_W-1:0] fr_angle,
  output logic               fr_has_next_angle,
  input  logic               fr_next_angle,
  output logic               fr_next_angle_ack,
  input  logic [S_W-1:0]     fr0_s_val,
  input  logic [S_W-1:0]     fr1_s_val,
  output logic [DATA_W-1:0]  fr0_val,
  output logic [DATA_W-1:0]  fr1_val,
  output logic               err_len
);

  localparam int              CNT_W    = $clog2(PROJ_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PROJ_LEN - 1);
  localparam logic [S_W:0]    HALF_LEN = (S_W + 1)'(PROJ_LEN / 2);
  localparam logic [S_W:0]    LEN_U    = (S_W + 1)'(PROJ_LEN);

  // Address is in range when non-negative and below the projection length.
  function automatic logic addr_in_range(input logic [S_W:0] addr);
    return (addr[S_W] == 1'b0) && ({1'b0, addr[S_W-1:0]} < LEN_U);
  endfunction

  wr_state_e          state_r, state_s;
  logic [CNT_W-1:0]   wr_cnt_r;
  logic [ANGLE_W-1:0] pend_angle_r;
  logic [ANGLE_W-1:0] fr_angle_r;
  logic               wr_sel_r, rd_sel_r;
  logic               flt_ready_r, has_next_r, err_len_r;
  logic               wr_en_s, last_s, ack_s;

  logic [S_W:0]       addr0_s, addr1_s;
  logic               rd0_ok_r, rd1_ok_r, rd_bank_r;
  logic [DATA_W-1:0]  b0_q0_s, b0_q1_s, b1_q0_s, b1_q1_s;

  // Next-state decode for the write FSM plus the combinational swap grant.
  always_comb begin
    state_s = state_r;
    wr_en_s = 1'b0;
    last_s  = (wr_cnt_r == LAST_CNT);
    ack_s   = fr_next_angle & has_next_r;
    case (state_r)
      WR_FILL: begin
        if (flt_valid) begin
          wr_en_s = 1'b1;
          if (last_s) begin
            state_s = WR_WAIT;
          end else begin
            state_s = WR_FILL;
          end
        end else begin
          state_s = WR_FILL;
        end
      end
      WR_WAIT: begin
        if (ack_s) begin
          state_s = WR_FILL;
        end else begin
          state_s = WR_WAIT;
        end
      end
      default: state_s = WR_FILL;
    endcase
  end

  // Write-side state, fill counter, pending angle, bank selects and sticky length error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= WR_FILL;
      wr_cnt_r     <= {CNT_W{1'b0}};
      pend_angle_r <= {ANGLE_W{1'b0}};
      fr_angle_r   <= {ANGLE_W{1'b0}};
      wr_sel_r     <= 1'b0;
      rd_sel_r     <= 1'b1;
      flt_ready_r  <= 1'b1;
      has_next_r   <= 1'b0;
      err_len_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      flt_ready_r <= (state_s == WR_FILL);
      has_next_r  <= (state_s == WR_WAIT);
      if (wr_en_s) begin
        // Counter wraps to zero on the final sample since PROJ_LEN is a power of two.
        wr_cnt_r <= wr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (wr_cnt_r == {CNT_W{1'b0}}) begin
          pend_angle_r <= flt_angle;
        end
        if (flt_last != last_s) begin
          err_len_r <= 1'b1;
        end
      end
      if (ack_s) begin
        rd_sel_r   <= wr_sel_r;
        wr_sel_r   <= ~wr_sel_r;
        fr_angle_r <= pend_angle_r;
      end
    end
  end

  assign addr0_s = {fr0_s_val[S_W-1], fr0_s_val} + HALF_LEN;
  assign addr1_s = {fr1_s_val[S_W-1], fr1_s_val} + HALF_LEN;

  // Capture range flags and bank select alongside the RAM read address.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd0_ok_r  <= 1'b0;
      rd1_ok_r  <= 1'b0;
      rd_bank_r <= 1'b0;
    end else begin
      rd0_ok_r  <= addr_in_range(addr0_s);
      rd1_ok_r  <= addr_in_range(addr1_s);
      rd_bank_r <= rd_sel_r;
    end
  end

  nabp_filtered_ram_swap_control_bank #(.DATA_W(DATA_W), .DEPTH(PROJ_LEN)) u_bank0 (
    .clk    (clk),
    .we     (wr_en_s & ~wr_sel_r),
    .waddr  (wr_cnt_r),
    .wdata  (flt_data),
    .raddr0 (addr0_s[CNT_W-1:0]),
    .raddr1 (addr1_s[CNT_W-1:0]),
    .rdata0 (b0_q0_s),
    .rdata1 (b0_q1_s)
  );

  nabp_filtered_ram_swap_control_bank #(.DATA_W(DATA_W), .DEPTH(PROJ_LEN)) u_bank1 (
    .clk    (clk),
    .we     (wr_en_s & wr_sel_r),
    .waddr  (wr_cnt_r),
    .wdata  (flt_data),
    .raddr0 (addr0_s[CNT_W-1:0]),
    .raddr1 (addr1_s[CNT_W-1:0]),
    .rdata0 (b1_q0_s),
    .rdata1 (b1_q1_s)
  );

  assign fr0_val           = rd0_ok_r ? (rd_bank_r ? b1_q0_s : b0_q0_s) : {DATA_W{1'b0}};
  assign fr1_val           = rd1_ok_r ? (rd_bank_r ? b1_q1_s : b0_q1_s) : {DATA_W{1'b0}};
  assign flt_ready         = flt_ready_r;
  assign fr_has_next_angle = has_next_r;
  assign fr_next_angle_ack = ack_s;
  assign fr_angle          = fr_angle_r;
  assign err_len           = err_len_r;

endmodule

// File: tb/tb_nabp_filtered_ram_swap_control.sv
// Directed self-checking bench for nabp_filtered_ram_swap_control.
module tb_nabp_filtered_ram_swap_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  flt_angle;
  logic        flt_valid;
  logic [11:0] flt_data;
  logic        flt_last;
  logic        flt_ready;
  logic [8:0]  fr_angle;
  logic        fr_has_next_angle;
  logic        fr_next_angle;
  logic        fr_next_angle_ack;
  logic [9:0]  fr0_s_val, fr1_s_val;
  logic [11:0] fr0_val, fr1_val;
  logic        err_len;

  int checks = 0;
  int errors = 0;

  nabp_filtered_ram_swap_control dut (
    .clk               (clk),
    .reset             (reset),
    .flt_angle         (flt_angle),
    .flt_valid         (flt_valid),
    .flt_data          (flt_data),
    .flt_last          (flt_last),
    .flt_ready         (flt_ready),
    .fr_angle          (fr_angle),
    .fr_has_next_angle (fr_has_next_angle),
    .fr_next_angle     (fr_next_angle),
    .fr_next_angle_ack (fr_next_angle_ack),
    .fr0_s_val         (fr0_s_val),
    .fr1_s_val         (fr1_s_val),
    .fr0_val           (fr0_val),
    .fr1_val           (fr1_val),
    .err_len           (err_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample pattern: mode 0 is a ramp equal to s, mode 1 is a distinct linear pattern.
  function automatic logic [11:0] sample(input int mode, input int idx);
    if (mode == 0) return 12'(idx - 256);
    return 12'(idx * 3 - 700);
  endfunction

  task automatic push(input int angle, input int first, input int last_excl,
                      input int last_idx, input int mode);
    for (int i = first; i < last_excl; i++) begin
      flt_valid = 1'b1;
      flt_angle = 9'(angle);
      flt_data  = sample(mode, i);
      flt_last  = (i == last_idx);
      @(negedge clk);
    end
    flt_valid = 1'b0;
    flt_last  = 1'b0;
  endtask

  task automatic rd(input string tag, input int s0, input int s1,
                    input logic [11:0] e0, input logic [11:0] e1);
    fr0_s_val = 10'(s0);
    fr1_s_val = 10'(s1);
    @(negedge clk);
    chk({tag, "_p0"}, {20'd0, fr0_val}, {20'd0, e0});
    chk({tag, "_p1"}, {20'd0, fr1_val}, {20'd0, e1});
  endtask

  task automatic swap(input int angle);
    fr_next_angle = 1'b1;
    #1;
    chk("swap_ack", {31'd0, fr_next_angle_ack}, 32'd1);
    @(negedge clk);
    fr_next_angle = 1'b0;
    chk("swap_angle", {23'd0, fr_angle}, 32'(angle));
    chk("swap_has_next", {31'd0, fr_has_next_angle}, 32'd0);
    chk("swap_ready", {31'd0, flt_ready}, 32'd1);
  endtask

  initial begin
    int rd_errs;
    reset = 1'b1; flt_angle = '0; flt_valid = 1'b0; flt_data = '0; flt_last = 1'b0;
    fr_next_angle = 1'b0; fr0_s_val = '0; fr1_s_val = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, flt_ready}, 32'd1);
    chk("rst_angle", {23'd0, fr_angle}, 32'd0);
    chk("rst_has_next", {31'd0, fr_has_next_angle}, 32'd0);
    chk("rst_ack", {31'd0, fr_next_angle_ack}, 32'd0);
    chk("rst_val0", {20'd0, fr0_val}, 32'd0);
    chk("rst_val1", {20'd0, fr1_val}, 32'd0);
    chk("rst_err", {31'd0, err_len}, 32'd0);
    reset = 1'b0;

    // Request mid-fill is ignored, then fill completes (angle 30, ramp).
    push(30, 0, 100, 511, 0);
    fr_next_angle = 1'b1;
    #1;
    chk("mid_ack", {31'd0, fr_next_angle_ack}, 32'd0);
    @(negedge clk);
    fr_next_angle = 1'b0;
    chk("mid_ready", {31'd0, flt_ready}, 32'd1);
    chk("mid_has_next", {31'd0, fr_has_next_angle}, 32'd0);
    chk("mid_angle", {23'd0, fr_angle}, 32'd0);
    push(30, 100, 512, 511, 0);
    chk("full_has_next", {31'd0, fr_has_next_angle}, 32'd1);
    chk("full_ready", {31'd0, flt_ready}, 32'd0);
    chk("full_err", {31'd0, err_len}, 32'd0);

    // Swap and read back the whole ramp on both ports.
    swap(30);
    rd_errs = errors;
    for (int s = -256; s < 256; s++) begin
      rd("ramp", s, -1 - s, 12'(s), 12'(-1 - s));
    end
    if (errors != rd_errs) $display("ramp readback had %0d bad reads", errors - rd_errs);

    // Boundaries.
    rd("oor", -257, 256, 12'd0, 12'd0);
    rd("first", -256, -256, 12'(-256), 12'(-256));
    rd("last", 255, 255, 12'd255, 12'd255);

    // Read in the ack cycle returns the old bank.
    rd("pre60", 5, 5, 12'd5, 12'd5);
    push(60, 0, 512, 511, 1);
    rd("hold60", 5, -256, 12'd5, 12'(-256));
    chk("hold_has_next", {31'd0, fr_has_next_angle}, 32'd1);
    fr0_s_val = 10'd5;
    fr_next_angle = 1'b1;
    #1;
    chk("ack60", {31'd0, fr_next_angle_ack}, 32'd1);
    @(negedge clk);
    fr_next_angle = 1'b0;
    chk("ackcyc_old", {20'd0, fr0_val}, {20'd0, sample(0, 261)});
    chk("ack_angle60", {23'd0, fr_angle}, 32'd60);
    @(negedge clk);
    chk("after_new", {20'd0, fr0_val}, {20'd0, sample(1, 261)});

    // Early flt_last: sticky error, bank still fills to 512.
    push(90, 0, 301, 300, 0);
    chk("early_err", {31'd0, err_len}, 32'd1);
    chk("early_has_next", {31'd0, fr_has_next_angle}, 32'd0);
    chk("early_ready", {31'd0, flt_ready}, 32'd1);
    push(90, 301, 511, 300, 0);
    chk("early_511_has_next", {31'd0, fr_has_next_angle}, 32'd0);
    push(90, 511, 512, 300, 0);
    chk("early_full", {31'd0, fr_has_next_angle}, 32'd1);
    chk("early_err_sticky", {31'd0, err_len}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("err_cleared", {31'd0, err_len}, 32'd0);
    chk("err_rst_has_next", {31'd0, fr_has_next_angle}, 32'd0);

    // Reset mid-fill with a previously swapped projection.
    push(45, 0, 512, 511, 0);
    swap(45);
    push(50, 0, 200, 511, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_has_next", {31'd0, fr_has_next_angle}, 32'd0);
    chk("mrst_ready", {31'd0, flt_ready}, 32'd1);
    chk("mrst_angle", {23'd0, fr_angle}, 32'd0);
    chk("mrst_err", {31'd0, err_len}, 32'd0);
    push(77, 0, 512, 511, 1);
    chk("refill_has_next", {31'd0, fr_has_next_angle}, 32'd1);
    chk("refill_err", {31'd0, err_len}, 32'd0);
    swap(77);
    rd("refill_a", -256, 5, sample(1, 0), sample(1, 261));
    rd("refill_b", 255, -100, sample(1, 511), sample(1, 156));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
